// File: rtl/tdr_readout.sv
// Readout controller for a thermometer time-domain register built from tdr_latch cells.
// Arms the latch bank, waits for the edge to settle, then converts the synchronized taps to a count.
module tdr_readout #(
    parameter int N_TAPS         = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         start,
    input  logic [N_TAPS-1:0]            carry_in,
    output logic                         latch_rstb,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(N_TAPS+1)-1:0]  out_code,
    output logic                         out_bubble,
    output logic                         out_timeout
);

    localparam int CODE_W  = $clog2(N_TAPS + 1);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                timeout_flag, timeout_flag_next;
    logic                latch_next, busy_next, valid_next;
    logic [CODE_W-1:0]   code_next;
    logic                bubble_next, out_timeout_next;
    logic [N_TAPS-1:0]   sync_q [SYNC_STAGES];
    logic [N_TAPS-1:0]   carry_sync;
    logic [CODE_W-1:0]   therm_code;
    logic                therm_bubble;

    // Independent per-bit synchronizer chains; skew between bits shows up as a bubble.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= carry_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign carry_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        therm_code = CODE_W'(N_TAPS);
        for (int i = N_TAPS - 1; i >= 0; i--) begin
            if (!carry_sync[i]) begin
                therm_code = CODE_W'(i);
            end
        end
        therm_bubble = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            if ((i > int'(therm_code)) && carry_sync[i]) begin
                therm_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        timeout_flag_next = timeout_flag;
        valid_next        = out_valid;
        code_next         = out_code;
        bubble_next       = out_bubble;
        out_timeout_next  = out_timeout;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next        = ARMED;
                    cnt_next          = '0;
                    timeout_flag_next = 1'b0;
                end
            end
            ARMED: begin
                // An event on the same cycle as the timeout takes priority.
                if ((cnt >= CNT_W'(SYNC_STAGES)) && carry_sync[0]) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next        = CAPTURE;
                    timeout_flag_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                code_next        = therm_code;
                bubble_next      = therm_bubble;
                out_timeout_next = timeout_flag;
                valid_next       = 1'b1;
                state_next       = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        latch_next = (state_next == ARMED) || (state_next == SETTLE) || (state_next == CAPTURE);
        busy_next  = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            cnt          <= '0;
            timeout_flag <= 1'b0;
            latch_rstb   <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_code     <= '0;
            out_bubble   <= 1'b0;
            out_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            timeout_flag <= timeout_flag_next;
            latch_rstb   <= latch_next;
            busy         <= busy_next;
            out_valid    <= valid_next;
            out_code     <= code_next;
            out_bubble   <= bubble_next;
            out_timeout  <= out_timeout_next;
        end
    end

endmodule

// File: tb/tb_tdr_readout.sv
// Self-checking bench for tdr_readout: directed scenarios plus randomized traffic
// compared every cycle against a timestamp/countdown model of the measurement sequence.
module tb_tdr_readout;

    localparam int N_TAPS         = 16;
    localparam int SYNC_STAGES    = 2;
    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 255;
    localparam int CODE_W         = $clog2(N_TAPS + 1);

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              start = 1'b0;
    logic [N_TAPS-1:0] carry_in = '0;
    logic              out_ready = 1'b0;
    logic              latch_rstb, busy, out_valid, out_bubble, out_timeout;
    logic [CODE_W-1:0] out_code;

    int errors = 0;
    int checks = 0;

    tdr_readout #(
        .N_TAPS(N_TAPS), .SYNC_STAGES(SYNC_STAGES),
        .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rstb(rstb), .start(start), .carry_in(carry_in),
        .latch_rstb(latch_rstb), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .out_bubble(out_bubble),
        .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: what the tap count and bubble flag of a captured word must be.
    function automatic void therm_eval(input logic [N_TAPS-1:0] v, output int code, output bit bubble);
        int word;
        code = N_TAPS;
        for (int i = 0; i < N_TAPS; i++) begin
            if (!v[i]) begin
                code = i;
                break;
            end
        end
        word   = int'(v);
        bubble = (code < N_TAPS) && ((word >> (code + 1)) != 0);
    endfunction

    // Model: busy/armed/hold flags, an armed-cycle count and a countdown to the capture edge.
    logic [N_TAPS-1:0] seen_q[$];
    bit m_busy, m_armed, m_hold, m_latch, m_valid, m_bubble, m_out_to, m_to_flag;
    int m_arm_k, m_wait, m_code;

    always @(posedge clk or negedge rstb) begin
        logic [N_TAPS-1:0] cs;
        int c;
        bit b;
        if (!rstb) begin
            seen_q.delete();
            for (int i = 0; i < SYNC_STAGES; i++) seen_q.push_back('0);
            m_busy = 0; m_armed = 0; m_hold = 0; m_latch = 0; m_valid = 0;
            m_bubble = 0; m_out_to = 0; m_to_flag = 0; m_arm_k = 0; m_wait = 0; m_code = 0;
        end else begin
            cs = seen_q.pop_front();
            seen_q.push_back(carry_in);
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_armed = 1; m_arm_k = 0; m_latch = 1; m_to_flag = 0;
                end
            end else if (m_armed) begin
                if (m_arm_k >= SYNC_STAGES && cs[0]) begin
                    m_armed = 0; m_wait = SETTLE_CYCLES + 1;
                end else if (m_arm_k == TIMEOUT_CYCLES - 1) begin
                    m_armed = 0; m_wait = 1; m_to_flag = 1;
                end else begin
                    m_arm_k++;
                end
            end else if (!m_hold) begin
                m_wait--;
                if (m_wait == 0) begin
                    therm_eval(cs, c, b);
                    m_code = c; m_bubble = b; m_out_to = m_to_flag;
                    m_valid = 1; m_hold = 1; m_latch = 0;
                end
            end else if (out_ready) begin
                m_valid = 0; m_hold = 0; m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstb) begin
            check_output("latch_rstb", int'(latch_rstb), int'(m_latch));
            check_output("busy", int'(busy), int'(m_busy));
            check_output("out_valid", int'(out_valid), int'(m_valid));
            check_output("out_code", int'(out_code), m_code);
            check_output("out_bubble", int'(out_bubble), int'(m_bubble));
            check_output("out_timeout", int'(out_timeout), int'(m_out_to));
        end
    end

    task automatic apply_stimulus(input bit st, input logic [N_TAPS-1:0] ci, input bit rdy);
        @(negedge clk);
        start     = st;
        carry_in  = ci;
        out_ready = rdy;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check_output({name, "_wait_valid"}, 0, 1);
    endtask

    // Start, let blanking pass with a clear bank, then present a tap pattern and wait for the result.
    task automatic measure(input logic [N_TAPS-1:0] pattern, input string name);
        apply_stimulus(1, '0, 0);
        apply_stimulus(0, '0, 0);
        apply_stimulus(0, '0, 0);
        apply_stimulus(0, '0, 0);
        apply_stimulus(0, pattern, 0);
        wait_valid(name);
    endtask

    task automatic accept_result(input string name);
        apply_stimulus(0, '0, 1);
        apply_stimulus(0, '0, 0);
        check_output({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        logic [31:0] t;
        int k;

        // Reset with every tap asserted.
        rstb = 1'b0;
        carry_in = '1;
        #1;
        check_output("t1_latch_rstb", int'(latch_rstb), 0);
        check_output("t1_out_valid", int'(out_valid), 0);
        check_output("t1_out_code", int'(out_code), 0);
        check_output("t1_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        carry_in = '0;
        rstb = 1'b1;

        measure(16'h003F, "t2");
        check_output("t2_code", int'(out_code), 6);
        check_output("t2_bubble", int'(out_bubble), 0);
        check_output("t2_timeout", int'(out_timeout), 0);
        check_output("t2_latch_low", int'(latch_rstb), 0);
        accept_result("t2");

        measure(16'h008F, "t3a");
        check_output("t3a_code", int'(out_code), 4);
        check_output("t3a_bubble", int'(out_bubble), 1);
        accept_result("t3a");

        measure(16'hFFFF, "t3b");
        check_output("t3b_code", int'(out_code), 16);
        check_output("t3b_bubble", int'(out_bubble), 0);
        accept_result("t3b");

        // Bank never fires: forced capture after the full armed window.
        apply_stimulus(1, '0, 0);
        apply_stimulus(0, '0, 0);
        for (int i = 0; i < TIMEOUT_CYCLES - 2; i++) apply_stimulus(0, '0, 0);
        check_output("t4_not_early", int'(out_valid), 0);
        wait_valid("t4");
        check_output("t4_timeout", int'(out_timeout), 1);
        check_output("t4_code", int'(out_code), 0);
        accept_result("t4");

        // Backpressure: result must hold while start pulses and taps wiggle.
        measure(16'h0007, "t5");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(i % 3 == 0, N_TAPS'($urandom), 0);
            check_output("t5_valid_held", int'(out_valid), 1);
            check_output("t5_code_held", int'(out_code), 3);
            check_output("t5_latch_low", int'(latch_rstb), 0);
        end
        accept_result("t5");

        // Reset while settling.
        apply_stimulus(1, '0, 0);
        apply_stimulus(0, '0, 0);
        apply_stimulus(0, '0, 0);
        apply_stimulus(0, 16'h00FF, 0);
        repeat (4) apply_stimulus(0, 16'h00FF, 0);
        check_output("t6_busy_before", int'(busy), 1);
        check_output("t6_latch_before", int'(latch_rstb), 1);
        #2 rstb = 1'b0;
        #1;
        check_output("t6_latch_rstb", int'(latch_rstb), 0);
        check_output("t6_busy", int'(busy), 0);
        check_output("t6_valid", int'(out_valid), 0);
        @(negedge clk);
        carry_in = '0;
        rstb = 1'b1;
        measure(16'h01FF, "t6r");
        check_output("t6r_code", int'(out_code), 9);
        check_output("t6r_bubble", int'(out_bubble), 0);
        accept_result("t6r");

        // Randomized traffic: mostly thermometer codes, some with a flipped bit.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, N_TAPS);
                t = (32'd1 << k) - 32'd1;
                if ($urandom_range(0, 3) == 0) t[$urandom_range(0, N_TAPS - 1)] ^= 1'b1;
                apply_stimulus($urandom_range(0, 3) == 0, t[N_TAPS-1:0], $urandom_range(0, 2) != 0);
            end else begin
                apply_stimulus($urandom_range(0, 3) == 0, carry_in, $urandom_range(0, 2) != 0);
            end
        end
        for (int i = 0; i < 300; i++) apply_stimulus(0, '0, 1);
        check_output("final_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
